// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int         WORD_W      = 16;
    localparam logic [7:0] TIMEOUT_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_PC = 3'd1,
        MEM   = 3'd2,
        INC   = 3'd3,
        HOLD  = 3'd4,
        JMP   = 3'd5,
        TURN  = 3'd6,
        FAULT = 3'd7
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive memory-wait cycles; expired flags the last allowed wait cycle.
module fetch_timeout_ctr
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_r;

    // Wait-cycle counter, saturating so it never wraps back into a legal window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable && (count_r != TIMEOUT_MAX)) begin
            count_r <= count_r + 8'd1;
        end
    end

    // count_r holds completed wait cycles, so this fires during the 255th one
    assign expired = enable && (count_r == (TIMEOUT_MAX - 8'd1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads the PC over a shared tri-state bus, fetches, hands off.
// Optional memory-wait timeout with a sticky FAULT state when FETCH_TIMEOUT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    inout  wire  [WORD_W-1:0] data_bus,
    output logic              pc_read,
    output logic              pc_set,
    output logic              pc_increment,
    output logic              pc_decrement,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_req,
    input  logic [WORD_W-1:0] jump_target,
    output logic              jump_ack,
    input  logic              halt,
    output logic              fault
);

    fetch_state_t      state_r;
    fetch_state_t      state_next_s;
    logic              pc_read_r;
    logic              pc_set_r;
    logic              pc_inc_r;
    logic              mem_req_r;
    logic              instr_valid_r;
    logic              jump_ack_r;
    logic              bus_oe_r;
    logic [WORD_W-1:0] mem_addr_r;
    logic [WORD_W-1:0] instr_r;
    logic              timeout_s;

`ifdef FETCH_TIMEOUT_EN
    logic fault_r;

    fetch_timeout_ctr u_timeout (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (state_r != MEM),
        .enable  (state_r == MEM),
        .expired (timeout_s)
    );

    // Sticky fault flag, mirrors the FAULT state one-for-one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= (state_next_s == FAULT);
        end
    end

    assign fault = fault_r;
`else
    assign timeout_s = 1'b0;
    assign fault     = 1'b0;
`endif

    // Next-state decision; jump_req is only honoured from IDLE so a fetch always finishes
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (jump_req) begin
                    state_next_s = JMP;
                end else if (!halt) begin
                    state_next_s = RD_PC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_PC: state_next_s = MEM;
            MEM: begin
                if (mem_ack) begin
                    state_next_s = INC;
                end else if (timeout_s) begin
                    state_next_s = FAULT;
                end else begin
                    state_next_s = MEM;
                end
            end
            INC: state_next_s = HOLD;
            HOLD: begin
                if (instr_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            JMP:   state_next_s = TURN;
            TURN:  state_next_s = IDLE;
            FAULT: state_next_s = FAULT;
            default: state_next_s = IDLE;
        endcase
    end

    // State plus outputs registered from the next state so every output is flop-driven
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            pc_read_r     <= 1'b0;
            pc_set_r      <= 1'b0;
            pc_inc_r      <= 1'b0;
            mem_req_r     <= 1'b0;
            instr_valid_r <= 1'b0;
            jump_ack_r    <= 1'b0;
            bus_oe_r      <= 1'b0;
            mem_addr_r    <= {WORD_W{1'b0}};
            instr_r       <= {WORD_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            pc_read_r     <= (state_next_s == RD_PC);
            pc_set_r      <= (state_next_s == JMP);
            pc_inc_r      <= (state_next_s == INC);
            mem_req_r     <= (state_next_s == MEM);
            instr_valid_r <= (state_next_s == HOLD);
            jump_ack_r    <= (state_next_s == JMP);
            bus_oe_r      <= (state_next_s == JMP);
            if (state_r == RD_PC) begin
                mem_addr_r <= data_bus;
            end
            if ((state_r == MEM) && mem_ack) begin
                instr_r <= mem_rdata;
            end
        end
    end

    // Only JMP drives the bus; the PC owns it during RD_PC, so the two never overlap
    assign data_bus = bus_oe_r ? jump_target : {WORD_W{1'bz}};

    assign pc_read      = pc_read_r;
    assign pc_set       = pc_set_r;
    assign pc_increment = pc_inc_r;
    assign pc_decrement = 1'b0;
    assign mem_req      = mem_req_r;
    assign mem_addr     = mem_addr_r;
    assign instr        = instr_r;
    assign instr_valid  = instr_valid_r;
    assign jump_ack     = jump_ack_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC/memory/consumer models, vector table, scoreboard.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    wire  [15:0] data_bus;
    logic        pc_read, pc_set, pc_increment, pc_decrement;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr, mem_rdata;
    logic [15:0] instr;
    logic        instr_valid, instr_ready;
    logic        jump_req, jump_ack;
    logic [15:0] jump_target;
    logic        halt, fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] pc;
        int          ack_dly;
        int          rdy_dly;
        logic [15:0] exp_instr;
        logic [15:0] exp_pc;
        int          exp_lat;
        int          exp_req;
    } vec_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] instr;
    } sb_t;

    vec_t vecs[6];
    sb_t  sb_q[$];

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .data_bus     (data_bus),
        .pc_read      (pc_read),
        .pc_set       (pc_set),
        .pc_increment (pc_increment),
        .pc_decrement (pc_decrement),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .jump_req     (jump_req),
        .jump_target  (jump_target),
        .jump_ack     (jump_ack),
        .halt         (halt),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model: drives the bus only while pc_read is high
    logic [15:0] pc_q;
    logic        pc_force;
    logic [15:0] pc_force_val;
    assign data_bus = pc_read ? pc_q : 16'hzzzz;
    always @(posedge clk) begin
        if (pc_force)          pc_q <= pc_force_val;
        else if (pc_set)       pc_q <= data_bus;
        else if (pc_increment) pc_q <= pc_q + 16'd1;
    end

    // Memory model with programmable ack delay; data is the inverted address
    int   ack_dly, ack_wait;
    logic ack_force;
    assign mem_rdata = ~mem_addr;
    assign mem_ack   = ack_force || (mem_req && (ack_wait >= ack_dly));
    always @(posedge clk) begin
        if (mem_req && !mem_ack) ack_wait <= ack_wait + 1;
        else                     ack_wait <= 0;
    end

    // Consumer model with programmable ready delay
    int rdy_dly, rdy_wait;
    assign instr_ready = instr_valid && (rdy_wait >= rdy_dly);
    always @(posedge clk) begin
        if (instr_valid && !instr_ready) rdy_wait <= rdy_wait + 1;
        else                             rdy_wait <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic        prev_req, prev_valid, prev_ready, prev_ack;
    logic [15:0] prev_addr, prev_instr;

    // Advance to the next falling edge and apply the always-on bus/protocol checks
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            chk("ctrl_onehot", 32'($countones({pc_read, pc_set, pc_increment}) <= 1), 32'd1);
            chk("pc_decrement", 32'(pc_decrement), 32'd0);
            if (pc_set)  chk("bus_jump_value", 32'(data_bus), 32'(jump_target));
            if (pc_read) chk("bus_read_clean", 32'(data_bus), 32'(pc_q));
            if (prev_req && mem_req) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
            if (prev_valid && !prev_ready && instr_valid)
                chk("instr_stable", 32'(instr), 32'(prev_instr));
            if (prev_ack) chk("jump_ack_pulse", 32'(jump_ack), 32'd0);
`ifndef FETCH_TIMEOUT_EN
            chk("fault_tied", 32'(fault), 32'd0);
`endif
            prev_req   = mem_req;
            prev_valid = instr_valid;
            prev_ready = instr_ready;
            prev_ack   = jump_ack;
            prev_addr  = mem_addr;
            prev_instr = instr;
        end else begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_ack   = 1'b0;
        end
    endtask

    // Load the PC (optionally), queue the expectation and let exactly one fetch begin
    task automatic start_fetch(input vec_t v, input bit force_pc);
        int n;
        if (force_pc) begin
            pc_force_val = v.pc;
            pc_force     = 1'b1;
            tick();
            pc_force     = 1'b0;
        end
        ack_dly = v.ack_dly;
        rdy_dly = v.rdy_dly;
        sb_q.push_back(sb_t'{addr: v.pc, instr: v.exp_instr});
        halt = 1'b0;
        n = 0;
        while (!pc_read && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_start", 32'(pc_read), 32'd1);
        halt = 1'b1;
    endtask

    // Follow the fetch from RD_PC to the handshake and check timing and results
    task automatic finish_fetch(input vec_t v, input int jump_at);
        int  n, req_c, inc_c, val_c, rd_c, first_val;
        bit  done;
        sb_t exp;
        n = 0; req_c = 0; inc_c = 0; val_c = 0; rd_c = 0; first_val = -1; done = 1'b0;
        while (!done && n < 300) begin
            tick();
            n++;
            if (n == jump_at) begin
                jump_target = 16'h1234;
                jump_req    = 1'b1;
            end
            if (pc_read) rd_c++;
            if (mem_req) req_c++;
            if (pc_increment) begin
                inc_c++;
                chk("inc_after_ack", 32'(req_c), 32'(v.exp_req));
            end
            if (instr_valid) begin
                val_c++;
                if (first_val < 0) first_val = n;
            end
            if (instr_valid && instr_ready) begin
                done = 1'b1;
                chk("sb_depth", 32'(sb_q.size()), 32'd1);
                if (sb_q.size() > 0) begin
                    exp = sb_q.pop_front();
                    chk("instr", 32'(instr), 32'(exp.instr));
                    chk("mem_addr", 32'(mem_addr), 32'(exp.addr));
                end
            end
        end
        chk("handshake_seen", 32'(done), 32'd1);
        chk("latency", 32'(first_val), 32'(v.exp_lat));
        chk("mem_req_cycles", 32'(req_c), 32'(v.exp_req));
        chk("inc_pulses", 32'(inc_c), 32'd1);
        chk("valid_cycles", 32'(val_c), 32'(v.rdy_dly + 1));
        chk("no_refetch", 32'(rd_c), 32'd0);
        tick();
        chk("pc_after", 32'(pc_q), 32'(v.exp_pc));
        chk("valid_drop", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        vec_t jv, rv;
        int   m, cnt;

        vecs[0] = '{16'h0010, 0, 0, 16'hFFEF, 16'h0011, 3, 1};
        vecs[1] = '{16'h1234, 5, 0, 16'hEDCB, 16'h1235, 8, 6};
        vecs[2] = '{16'h0800, 0, 3, 16'hF7FF, 16'h0801, 3, 1};
        vecs[3] = '{16'hFFFF, 0, 0, 16'h0000, 16'h0000, 3, 1};
        vecs[4] = '{16'h00FF, 2, 1, 16'hFF00, 16'h0100, 5, 3};
        vecs[5] = '{16'h8000, 1, 2, 16'h7FFF, 16'h8001, 4, 2};

        reset = 1'b0; halt = 1'b1; jump_req = 1'b0; jump_target = 16'h0000;
        pc_force = 1'b1; pc_force_val = 16'h0010; ack_force = 1'b0;
        ack_dly = 0; rdy_dly = 0;
        tick();
        tick();
        chk("rst_pc_read", 32'(pc_read), 32'd0);
        chk("rst_pc_set", 32'(pc_set), 32'd0);
        chk("rst_pc_inc", 32'(pc_increment), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_jump_ack", 32'(jump_ack), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);

        // First fetch must begin on the first rising edge after release
        sb_q.push_back(sb_t'{addr: vecs[0].pc, instr: vecs[0].exp_instr});
        halt = 1'b0;
        reset = 1'b1;
        pc_force = 1'b0;
        tick();
        chk("first_fetch", 32'(pc_read), 32'd1);
        halt = 1'b1;
        finish_fetch(vecs[0], -1);

        for (int i = 1; i < 6; i++) begin
            start_fetch(vecs[i], 1'b1);
            finish_fetch(vecs[i], -1);
        end

        // Jump raised mid-MEM is deferred until the fetch completes
        jv = '{16'h0040, 3, 0, 16'hFFBF, 16'h0041, 6, 4};
        start_fetch(jv, 1'b1);
        finish_fetch(jv, 2);
        m = 0;
        while (!jump_ack && m < 10) begin
            tick();
            m++;
        end
        chk("jump_delay", 32'(m), 32'd1);
        chk("jump_pc_set", 32'(pc_set), 32'd1);
        chk("jump_bus", 32'(data_bus), 32'h1234);
        chk("jump_sb_empty", 32'(sb_q.size()), 32'd0);
        jump_req = 1'b0;
        tick();
        chk("turn_ack", 32'(jump_ack), 32'd0);
        chk("turn_set", 32'(pc_set), 32'd0);
        chk("turn_read", 32'(pc_read), 32'd0);
        chk("turn_req", 32'(mem_req), 32'd0);
        tick();
        chk("jump_pc", 32'(pc_q), 32'h1234);
        rv = '{16'h1234, 0, 0, 16'hEDCB, 16'h1235, 3, 1};
        start_fetch(rv, 1'b0);
        finish_fetch(rv, -1);

        // Jump wins over a fetch requested in the same IDLE cycle
        jump_target = 16'hBEEF;
        jump_req = 1'b1;
        halt = 1'b0;
        tick();
        chk("prio_jump_ack", 32'(jump_ack), 32'd1);
        chk("prio_no_read", 32'(pc_read), 32'd0);
        jump_req = 1'b0;
        halt = 1'b1;
        tick();
        chk("prio_turn_read", 32'(pc_read), 32'd0);
        tick();
        chk("prio_pc", 32'(pc_q), 32'hBEEF);

        // halt keeps the unit idle
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pc_read || mem_req) cnt++;
        end
        chk("halt_idle", 32'(cnt), 32'd0);

        // Reset in the middle of MEM drops mem_req at once; a late ack is ignored
        rv = '{16'h2222, 1000, 0, 16'hDDDD, 16'h2223, 3, 1};
        start_fetch(rv, 1'b1);
        tick();
        tick();
        chk("pre_reset_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_drops_req", 32'(mem_req), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        sb_q.delete();
        ack_force = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("ack_ignored_req", 32'(mem_req), 32'd0);
        chk("ack_ignored_instr", 32'(instr), 32'd0);
        chk("ack_ignored_valid", 32'(instr_valid), 32'd0);
        ack_force = 1'b0;
        start_fetch(vecs[3], 1'b1);
        finish_fetch(vecs[3], -1);

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: fault after 255 wait cycles, cleared only by reset
        rv = '{16'h3000, 100000, 0, 16'hCFFF, 16'h3001, 3, 1};
        start_fetch(rv, 1'b1);
        m = 0;
        cnt = 0;
        while (!fault && m < 400) begin
            tick();
            m++;
            if (mem_req) cnt++;
        end
        chk("timeout_fault", 32'(fault), 32'd1);
        chk("timeout_cycles", 32'(cnt), 32'd255);
        chk("timeout_req_low", 32'(mem_req), 32'd0);
        sb_q.delete();
        ack_force = 1'b1;
        tick();
        tick();
        chk("fault_sticky", 32'(fault), 32'd1);
        reset = 1'b0;
        tick();
        chk("fault_cleared", 32'(fault), 32'd0);
        reset = 1'b1;
        ack_force = 1'b0;
        start_fetch(vecs[1], 1'b1);
        finish_fetch(vecs[1], -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
